// File: rtl/penguin_pkg.sv
// Shared definitions for the penguin movement block, the sprite renderer and
// the wall-probe mux: direction and state encodings, HID keycodes, key decode.
package penguin_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PROBE    = 2'd1,
        S_MOVE     = 2'd2,
        S_INTERACT = 2'd3
    } state_t;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_E = 8'h08;

    // True for the four movement keys (W/A/S/D)
    function automatic logic is_dir_key(input logic [7:0] key);
        return (key == KEY_A) || (key == KEY_D) || (key == KEY_W) || (key == KEY_S);
    endfunction

    // Direction selected by a movement key; only meaningful when is_dir_key() is true
    function automatic logic [1:0] key_to_dir(input logic [7:0] key);
        logic [1:0] d;
        case (key)
            KEY_A:   d = DIR_LEFT;
            KEY_D:   d = DIR_RIGHT;
            KEY_W:   d = DIR_UP;
            default: d = DIR_DOWN;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/penguin_step_calc.sv
// Combinational next-position calculator. Moves one axis by STEP according to
// dir (LEFT/RIGHT on X, UP/DOWN on Y, screen coordinates so UP decreases Y) and
// clamps to the inclusive [MIN,MAX] window. Arithmetic is done in 11 bits so the
// result never wraps.
module penguin_step_calc
    import penguin_pkg::*;
#(
    parameter logic [9:0] STEP  = 10'd4,
    parameter logic [9:0] X_MIN = 10'd20,
    parameter logic [9:0] X_MAX = 10'd600,
    parameter logic [9:0] Y_MIN = 10'd20,
    parameter logic [9:0] Y_MAX = 10'd440
) (
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [1:0] dir,
    output logic [9:0] next_x,
    output logic [9:0] next_y
);

    logic [9:0] pos_a  [2];
    logic [9:0] next_a [2];

    assign pos_a[0] = pos_x;
    assign pos_a[1] = pos_y;
    assign next_x   = next_a[0];
    assign next_y   = next_a[1];

    // Axis 0 is X, axis 1 is Y; both use the same clamp rule with their own limits
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [9:0] LO      = (gi == 0) ? X_MIN : Y_MIN;
            localparam logic [9:0] HI      = (gi == 0) ? X_MAX : Y_MAX;
            localparam logic [1:0] INC_DIR = (gi == 0) ? DIR_RIGHT : DIR_DOWN;
            localparam logic [1:0] DEC_DIR = (gi == 0) ? DIR_LEFT : DIR_UP;

            logic [10:0] inc_sum;
            logic [10:0] dec_floor;
            logic [9:0]  inc_res;
            logic [9:0]  dec_res;

            assign inc_sum   = {1'b0, pos_a[gi]} + {1'b0, STEP};
            assign dec_floor = {1'b0, LO} + {1'b0, STEP};
            assign inc_res   = (inc_sum > {1'b0, HI}) ? HI : inc_sum[9:0];
            assign dec_res   = ({1'b0, pos_a[gi]} < dec_floor) ? LO : (pos_a[gi] - STEP);

            assign next_a[gi] = (dir == INC_DIR) ? inc_res :
                                (dir == DEC_DIR) ? dec_res : pos_a[gi];
        end
    endgenerate

endmodule

// File: rtl/penguin_move_ctrl.sv
// Per-frame penguin sequencer. On a frame tick it latches the key, presents the
// current position and a direction to the shared wall-probe port, samples the
// checker one cycle later, then either steps the position or runs a
// request/ack handshake with the counter-item logic (with timeout).
module penguin_move_ctrl
    import penguin_pkg::*;
#(
    parameter logic [9:0] STEP    = 10'd4,
    parameter logic [9:0] X_INIT  = 10'd320,
    parameter logic [9:0] Y_INIT  = 10'd240,
    parameter logic [9:0] X_MIN   = 10'd20,
    parameter logic [9:0] X_MAX   = 10'd600,
    parameter logic [9:0] Y_MIN   = 10'd20,
    parameter logic [9:0] Y_MAX   = 10'd440,
    parameter logic [3:0] ACK_TMO = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    output logic [9:0] probe_x,
    output logic [9:0] probe_y,
    output logic [1:0] probe_dir,
    input  logic       touch_flag,
    input  logic [9:0] near_cx,
    input  logic [9:0] near_cy,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [1:0] facing,
    output logic       interact_req,
    output logic [9:0] int_cx,
    output logic [9:0] int_cy,
    input  logic       interact_ack,
    output logic       interact_none,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE     = S_IDLE;
    localparam logic [1:0] ST_PROBE    = S_PROBE;
    localparam logic [1:0] ST_MOVE     = S_MOVE;
    localparam logic [1:0] ST_INTERACT = S_INTERACT;

    logic [1:0] state_reg;
    logic [9:0] pos_x_reg, pos_y_reg;
    logic [1:0] facing_reg;
    logic [9:0] probe_x_reg, probe_y_reg;
    logic [1:0] probe_dir_reg;
    logic       key_is_e_reg;
    logic       touch_reg;
    logic [9:0] near_cx_reg, near_cy_reg;
    logic       interact_req_reg;
    logic [9:0] int_cx_reg, int_cy_reg;
    logic       interact_none_reg;
    logic [3:0] tmo_reg;
    logic [3:0] tmo_next;
    logic [9:0] step_x, step_y;

    assign tmo_next = tmo_reg + 4'd1;

    // The probe direction doubles as the latched movement direction for the frame
    penguin_step_calc #(
        .STEP  (STEP),
        .X_MIN (X_MIN),
        .X_MAX (X_MAX),
        .Y_MIN (Y_MIN),
        .Y_MAX (Y_MAX)
    ) u_step_calc (
        .pos_x  (pos_x_reg),
        .pos_y  (pos_y_reg),
        .dir    (probe_dir_reg),
        .next_x (step_x),
        .next_y (step_y)
    );

    // Frame sequencer: IDLE -> PROBE -> MOVE -> (IDLE | INTERACT -> IDLE)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            pos_x_reg         <= X_INIT;
            pos_y_reg         <= Y_INIT;
            facing_reg        <= DIR_DOWN;
            probe_x_reg       <= '0;
            probe_y_reg       <= '0;
            probe_dir_reg     <= '0;
            key_is_e_reg      <= 1'b0;
            touch_reg         <= 1'b0;
            near_cx_reg       <= '0;
            near_cy_reg       <= '0;
            interact_req_reg  <= 1'b0;
            int_cx_reg        <= '0;
            int_cy_reg        <= '0;
            interact_none_reg <= 1'b0;
            tmo_reg           <= '0;
        end else begin
            interact_none_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // Ticks arriving in any other state are dropped, not queued
                    if (frame_tick) begin
                        if (is_dir_key(keycode)) begin
                            probe_dir_reg <= key_to_dir(keycode);
                            facing_reg    <= key_to_dir(keycode);
                            probe_x_reg   <= pos_x_reg;
                            probe_y_reg   <= pos_y_reg;
                            key_is_e_reg  <= 1'b0;
                            state_reg     <= ST_PROBE;
                        end else if (keycode == KEY_E) begin
                            probe_dir_reg <= facing_reg;
                            probe_x_reg   <= pos_x_reg;
                            probe_y_reg   <= pos_y_reg;
                            key_is_e_reg  <= 1'b1;
                            state_reg     <= ST_PROBE;
                        end
                    end
                end
                ST_PROBE: begin
                    touch_reg   <= touch_flag;
                    near_cx_reg <= near_cx;
                    near_cy_reg <= near_cy;
                    state_reg   <= ST_MOVE;
                end
                ST_MOVE: begin
                    if (!key_is_e_reg) begin
                        if (!touch_reg) begin
                            pos_x_reg <= step_x;
                            pos_y_reg <= step_y;
                        end
                        state_reg <= ST_IDLE;
                    end else if (touch_reg) begin
                        int_cx_reg       <= near_cx_reg;
                        int_cy_reg       <= near_cy_reg;
                        interact_req_reg <= 1'b1;
                        tmo_reg          <= '0;
                        state_reg        <= ST_INTERACT;
                    end else begin
                        interact_none_reg <= 1'b1;
                        state_reg         <= ST_IDLE;
                    end
                end
                ST_INTERACT: begin
                    // An ack in the timeout cycle still counts as success
                    if (interact_ack) begin
                        interact_req_reg <= 1'b0;
                        state_reg        <= ST_IDLE;
                    end else begin
                        tmo_reg <= tmo_next;
                        if (tmo_next == ACK_TMO) begin
                            interact_req_reg  <= 1'b0;
                            interact_none_reg <= 1'b1;
                            state_reg         <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign probe_x       = probe_x_reg;
    assign probe_y       = probe_y_reg;
    assign probe_dir     = probe_dir_reg;
    assign pos_x         = pos_x_reg;
    assign pos_y         = pos_y_reg;
    assign facing        = facing_reg;
    assign interact_req  = interact_req_reg;
    assign int_cx        = int_cx_reg;
    assign int_cy        = int_cy_reg;
    assign interact_none = interact_none_reg;
    assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_penguin_move_ctrl.sv
// Bench for penguin_move_ctrl: directed frames drive a transaction-level model
// of the expected outputs; a negedge process compares every output each cycle,
// and literal expectations pin the model at key points.
module tb_penguin_move_ctrl;

    localparam int STEP = 4, XMIN = 20, XMAX = 600, YMIN = 20, YMAX = 440;
    localparam int XI = 320, YI = 240, TMO = 15;
    localparam logic [7:0] KA = 8'h04, KD = 8'h07, KW = 8'h1A, KS = 8'h16, KE = 8'h08;

    logic       clk, rst, frame_tick, touch_flag, interact_ack;
    logic [7:0] keycode;
    logic [9:0] near_cx, near_cy, probe_x, probe_y, pos_x, pos_y, int_cx, int_cy;
    logic [1:0] probe_dir, facing;
    logic       interact_req, interact_none, busy;

    penguin_move_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .keycode(keycode),
        .probe_x(probe_x), .probe_y(probe_y), .probe_dir(probe_dir),
        .touch_flag(touch_flag), .near_cx(near_cx), .near_cy(near_cy),
        .pos_x(pos_x), .pos_y(pos_y), .facing(facing),
        .interact_req(interact_req), .int_cx(int_cx), .int_cy(int_cy),
        .interact_ack(interact_ack), .interact_none(interact_none), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected output state (transaction-level model)
    int m_x = XI, m_y = YI, m_facing = 3;
    int e_px = 0, e_py = 0, e_pdir = 0;
    int e_busy = 0, e_req = 0, e_none = 0, e_icx = 0, e_icy = 0;
    int e_int_chk = 1;

    int req_cycles = 0, none_pulses = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_x = XI; m_y = YI; m_facing = 3;
        e_px = 0; e_py = 0; e_pdir = 0;
        e_busy = 0; e_req = 0; e_none = 0; e_icx = 0; e_icy = 0; e_int_chk = 1;
    endtask

    // Screen coordinates: up decreases Y. Positions saturate at the window edges.
    task automatic model_move(input int dir);
        case (dir)
            0: m_x = (m_x - STEP < XMIN) ? XMIN : m_x - STEP;
            1: m_x = (m_x + STEP > XMAX) ? XMAX : m_x + STEP;
            2: m_y = (m_y - STEP < YMIN) ? YMIN : m_y - STEP;
            default: m_y = (m_y + STEP > YMAX) ? YMAX : m_y + STEP;
        endcase
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("pos_x", int'(pos_x), m_x);
        chk("pos_y", int'(pos_y), m_y);
        chk("facing", int'(facing), m_facing);
        chk("probe_x", int'(probe_x), e_px);
        chk("probe_y", int'(probe_y), e_py);
        chk("probe_dir", int'(probe_dir), e_pdir);
        chk("busy", int'(busy), e_busy);
        chk("interact_req", int'(interact_req), e_req);
        chk("interact_none", int'(interact_none), e_none);
        if (e_req != 0 || e_int_chk != 0) begin
            chk("int_cx", int'(int_cx), e_icx);
            chk("int_cy", int'(int_cy), e_icy);
        end
        if (interact_req) req_cycles++;
        if (interact_none) none_pulses++;
    end

    // One frame: tick with key, hold touch/near, optional ack at INTERACT cycle
    // ack_n, optional ignored tick at cycle tick_c, optional reset at cycle abort_c.
    task automatic run_frame(input logic [7:0] key, input logic touch,
                             input int nx, input int ny,
                             input int ack_n, input int tick_c, input int abort_c);
        int dir;
        bit is_dir, is_e;
        is_dir = (key == KA) || (key == KD) || (key == KW) || (key == KS);
        is_e   = (key == KE);
        dir    = (key == KA) ? 0 : (key == KD) ? 1 : (key == KW) ? 2 : 3;
        req_cycles = 0; none_pulses = 0;
        keycode = key; frame_tick = 1'b1; touch_flag = touch;
        near_cx = 10'(nx); near_cy = 10'(ny);
        step();                                  // E0
        frame_tick = 1'b0;
        keycode = (key == KE) ? KA : KE;         // must not disturb the frame in progress
        if (is_dir || is_e) begin
            if (is_dir) m_facing = dir;
            e_pdir = is_e ? m_facing : dir;
            e_px = m_x; e_py = m_y; e_busy = 1; e_int_chk = 0;
            step();                              // E1
            step();                              // E2
            if (is_dir) begin
                if (!touch) model_move(dir);
                e_busy = 0;
            end else if (touch) begin
                e_req = 1; e_icx = nx; e_icy = ny;
                for (int c = 1; c <= TMO; c++) begin
                    if (c == abort_c) begin
                        rst = 1'b1;
                        #1;
                        model_reset();
                        step();
                        rst = 1'b0;
                        return;
                    end
                    interact_ack = (c == ack_n);
                    if (c == tick_c) begin
                        frame_tick = 1'b1; keycode = KD;
                    end
                    step();
                    interact_ack = 1'b0; frame_tick = 1'b0;
                    if (c == ack_n) begin
                        e_req = 0; e_busy = 0;
                        break;
                    end
                    if (c == TMO) begin
                        e_req = 0; e_busy = 0; e_none = 1;
                        step();
                        e_none = 0;
                    end
                end
            end else begin
                e_busy = 0; e_none = 1;
                step();
                e_none = 0;
            end
        end
        touch_flag = 1'b0;
        step();
    endtask

    initial begin
        int guard;
        rst = 1'b1; frame_tick = 1'b0; keycode = 8'h00; touch_flag = 1'b0;
        near_cx = '0; near_cy = '0; interact_ack = 1'b0;
        model_reset();
        step(); step(); step();
        rst = 1'b0;
        step(); step();

        // Reset state
        chk("t1_pos_x", int'(pos_x), 320);
        chk("t1_pos_y", int'(pos_y), 240);
        chk("t1_facing", int'(facing), 3);
        chk("t1_req", int'(interact_req), 0);
        chk("t1_busy", int'(busy), 0);

        // Stray ack while idle has no effect
        interact_ack = 1'b1; step(); interact_ack = 1'b0; step();

        // Single left step
        run_frame(KA, 1'b0, 0, 0, 0, 0, 0);
        chk("t2_pos_x", int'(pos_x), 316);
        chk("t2_facing", int'(facing), 0);

        // Unmapped key: nothing happens
        run_frame(8'h10, 1'b0, 0, 0, 0, 0, 0);
        chk("t2_other_pos_x", int'(pos_x), 316);

        // Walk left into the clamp, then one extra frame
        guard = 0;
        while (m_x > XMIN && guard < 200) begin
            run_frame(KA, 1'b0, 0, 0, 0, 0, 0);
            guard++;
        end
        run_frame(KA, 1'b0, 0, 0, 0, 0, 0);
        chk("t3_pos_x_clamp", int'(pos_x), 20);

        // Blocked move turns the penguin only
        run_frame(KD, 1'b1, 0, 0, 0, 0, 0);
        chk("t4_pos_x", int'(pos_x), 20);
        chk("t4_facing", int'(facing), 1);

        // Interact with ack after 3 cycles
        run_frame(KE, 1'b1, 340, 220, 3, 0, 0);
        chk("t4_req_cycles", req_cycles, 3);
        chk("t4_none", none_pulses, 0);
        chk("t4_busy", int'(busy), 0);

        // E with nothing in front
        run_frame(KE, 1'b0, 0, 0, 0, 0, 0);
        chk("t4_none_pulse", none_pulses, 1);

        // Timeout, then ack on the very last cycle
        run_frame(KE, 1'b1, 100, 200, 0, 0, 0);
        chk("t5_tmo_req_cycles", req_cycles, 15);
        chk("t5_tmo_none", none_pulses, 1);
        run_frame(KE, 1'b1, 101, 201, 15, 0, 0);
        chk("t5_ack15_req_cycles", req_cycles, 15);
        chk("t5_ack15_none", none_pulses, 0);

        // Vertical moves and bottom clamp
        run_frame(KW, 1'b0, 0, 0, 0, 0, 0);
        chk("t5_pos_y_up", int'(pos_y), 236);
        guard = 0;
        while (m_y < YMAX && guard < 200) begin
            run_frame(KS, 1'b0, 0, 0, 0, 0, 0);
            guard++;
        end
        run_frame(KS, 1'b0, 0, 0, 0, 0, 0);
        chk("t5_pos_y_clamp", int'(pos_y), 440);
        chk("t5_facing_down", int'(facing), 3);

        // Tick during INTERACT is ignored
        run_frame(KE, 1'b1, 55, 66, 8, 4, 0);
        chk("t6_tick_facing", int'(facing), 3);
        chk("t6_tick_pos_x", int'(pos_x), 20);

        // Reset mid-INTERACT
        run_frame(KE, 1'b1, 77, 88, 0, 0, 6);
        step();
        chk("t6_rst_req", int'(interact_req), 0);
        chk("t6_rst_pos_x", int'(pos_x), 320);
        chk("t6_rst_pos_y", int'(pos_y), 240);
        chk("t6_rst_none", none_pulses, 0);

        // Normal operation after reset
        run_frame(KD, 1'b0, 0, 0, 0, 0, 0);
        chk("t6_after_pos_x", int'(pos_x), 324);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
